// File: rtl/rh_latch_ctrl.sv
// Arbitrated pulse controller for a cross-coupled SR latch with active-low R/H inputs.
// Two requesters share the latch; each operation is pulse, settle, then read-back check.
module rh_latch_ctrl #(
   parameter int unsigned PW = 2,
   parameter int unsigned ST = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic a_req_i,
   input  logic a_op_i,
   output logic a_ack_o,
   output logic a_err_o,
   input  logic b_req_i,
   input  logic b_op_i,
   output logic b_ack_o,
   output logic b_err_o,
   output logic lr_o,
   output logic lh_o,
   input  logic lp_i,
   input  logic lq_i,
   output logic busy_o
);

   localparam logic [7:0] PwEff = (PW == 0) ? 8'd1 : 8'(PW);
   localparam logic [7:0] StEff = (ST == 0) ? 8'd1 : 8'(ST);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StPulse  = 2'b01,
      StSettle = 2'b10,
      StCheck  = 2'b11
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       gnt_q, gnt_d;   // 0 = A, 1 = B
   logic       op_q, op_d;
   logic       last_q, last_d; // last served requester, same encoding as gnt
   logic       lr_q, lr_d;
   logic       lh_q, lh_d;
   logic       mism;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         gnt_q   <= 1'b0;
         op_q    <= 1'b0;
         last_q  <= 1'b1;
         lr_q    <= 1'b1;
         lh_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         last_q  <= last_d;
         lr_q    <= lr_d;
         lh_q    <= lh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (a_req_i || b_req_i) begin
               if (a_req_i && b_req_i) begin
                  gnt_d = ~last_q;
               end else begin
                  gnt_d = b_req_i;
               end
               op_d    = gnt_d ? b_op_i : a_op_i;
               last_d  = gnt_d;
               state_d = StPulse;
               cnt_d   = 8'd1;
            end
         end
         StPulse: begin
            if (cnt_q >= PwEff) begin
               state_d = StSettle;
               cnt_d   = 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StSettle: begin
            if (cnt_q >= StEff) begin
               state_d = StCheck;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StCheck: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
      // Line drive follows the next state so the flops are low exactly while in PULSE.
      lr_d = !((state_d == StPulse) && !op_d);
      lh_d = !((state_d == StPulse) && op_d);
   end

   assign mism    = (lp_i != op_q) || (lq_i != ~op_q);
   assign busy_o  = (state_q != StIdle);
   assign a_ack_o = (state_q == StCheck) && !gnt_q;
   assign b_ack_o = (state_q == StCheck) && gnt_q;
   assign a_err_o = a_ack_o && mism;
   assign b_err_o = b_ack_o && mism;
   assign lr_o    = lr_q;
   assign lh_o    = lh_q;

endmodule

// File: tb/tb_rh_latch_ctrl.sv
// Directed bench for rh_latch_ctrl: default instance plus a PW=0/ST=0 instance,
// each driving a behavioural SR latch model.
module tb_rh_latch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Default instance
   logic a_req = 0, a_op = 0, b_req = 0, b_op = 0;
   logic a_ack, a_err, b_ack, b_err, lr, lh, lp, lq, busy;
   logic stuck = 0;
   logic p_lat = 0;

   rh_latch_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .a_req_i (a_req),
      .a_op_i  (a_op),
      .a_ack_o (a_ack),
      .a_err_o (a_err),
      .b_req_i (b_req),
      .b_op_i  (b_op),
      .b_ack_o (b_ack),
      .b_err_o (b_err),
      .lr_o    (lr),
      .lh_o    (lh),
      .lp_i    (lp),
      .lq_i    (lq),
      .busy_o  (busy)
   );

   always @(lr or lh) begin
      if (!lr) p_lat = 1'b0;
      else if (!lh) p_lat = 1'b1;
   end
   assign lp = stuck ? 1'b0 : p_lat;
   assign lq = ~lp;

   // Zero-parameter instance
   logic z_a_req = 0, z_a_op = 0, z_b_req = 0, z_b_op = 0;
   logic z_a_ack, z_a_err, z_b_ack, z_b_err, z_lr, z_lh, z_lp, z_lq, z_busy;
   logic z_p = 0;

   rh_latch_ctrl #(.PW(0), .ST(0)) dut0 (
      .clk     (clk),
      .rst     (rst),
      .a_req_i (z_a_req),
      .a_op_i  (z_a_op),
      .a_ack_o (z_a_ack),
      .a_err_o (z_a_err),
      .b_req_i (z_b_req),
      .b_op_i  (z_b_op),
      .b_ack_o (z_b_ack),
      .b_err_o (z_b_err),
      .lr_o    (z_lr),
      .lh_o    (z_lh),
      .lp_i    (z_lp),
      .lq_i    (z_lq),
      .busy_o  (z_busy)
   );

   always @(z_lr or z_lh) begin
      if (!z_lr) z_p = 1'b0;
      else if (!z_lh) z_p = 1'b1;
   end
   assign z_lp = z_p;
   assign z_lq = ~z_p;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input string tag, input logic e_lr, input logic e_lh, input logic e_busy,
                      input logic e_aa, input logic e_ba);
      chk({tag, ".lr"}, lr, e_lr);
      chk({tag, ".lh"}, lh, e_lh);
      chk({tag, ".busy"}, busy, e_busy);
      chk({tag, ".a_ack"}, a_ack, e_aa);
      chk({tag, ".b_ack"}, b_ack, e_ba);
   endtask

   // Line safety and ack sanity on every cycle, both instances.
   always @(negedge clk) begin
      chk("never_00", {lr, lh} == 2'b00, 1'b0);
      chk("z_never_00", {z_lr, z_lh} == 2'b00, 1'b0);
      chk("ack_only_busy", (a_ack | b_ack) & ~busy, 1'b0);
      chk("one_ack", a_ack & b_ack, 1'b0);
      chk("z_ack_only_busy", (z_a_ack | z_b_ack) & ~z_busy, 1'b0);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      cyc("rst", 1, 1, 0, 0, 0);
      chk("rst.a_err", a_err, 0);
      chk("rst.b_err", b_err, 0);
      chk("rst.z_busy", z_busy, 0);
      rst = 0;
      @(negedge clk);

      // Single set request from A
      a_req = 1; a_op = 1;
      cyc("t1c0", 1, 1, 0, 0, 0);
      tick(); cyc("t1c1", 1, 0, 1, 0, 0);
      tick(); cyc("t1c2", 1, 0, 1, 0, 0);
      tick(); cyc("t1c3", 1, 1, 1, 0, 0);
      tick(); cyc("t1c4", 1, 1, 1, 0, 0);
      tick(); cyc("t1c5", 1, 1, 1, 1, 0);
      chk("t1c5.a_err", a_err, 0);
      a_req = 0;
      tick(); cyc("t1c6", 1, 1, 0, 0, 0);
      chk("t1.lp", lp, 1);
      chk("t1.lq", lq, 0);

      // Tie after reset: A (clear) first, then B (set)
      rst = 1; tick(); rst = 0;
      a_req = 1; a_op = 0; b_req = 1; b_op = 1;
      cyc("t2c0", 1, 1, 0, 0, 0);
      tick(); cyc("t2c1", 0, 1, 1, 0, 0);
      tick(); cyc("t2c2", 0, 1, 1, 0, 0);
      tick(); cyc("t2c3", 1, 1, 1, 0, 0);
      tick(); cyc("t2c4", 1, 1, 1, 0, 0);
      tick(); cyc("t2c5", 1, 1, 1, 1, 0);
      chk("t2c5.a_err", a_err, 0);
      chk("t2c5.lp", lp, 0);
      a_req = 0;
      tick(); cyc("t2c6", 1, 1, 0, 0, 0);
      tick(); cyc("t2c7", 1, 0, 1, 0, 0);
      tick(); cyc("t2c8", 1, 0, 1, 0, 0);
      tick(); cyc("t2c9", 1, 1, 1, 0, 0);
      tick(); cyc("t2c10", 1, 1, 1, 0, 0);
      tick(); cyc("t2c11", 1, 1, 1, 0, 1);
      chk("t2c11.b_err", b_err, 0);
      b_req = 0;
      tick(); cyc("t2c12", 1, 1, 0, 0, 0);
      chk("t2.lp", lp, 1);

      // Latch stuck at P=0, B asks for set
      stuck = 1; b_req = 1; b_op = 1;
      repeat (5) tick();
      cyc("t3c5", 1, 1, 1, 0, 1);
      chk("t3c5.b_err", b_err, 1);
      chk("t3c5.a_err", a_err, 0);
      b_req = 0;
      tick(); cyc("t3c6", 1, 1, 0, 0, 0);
      stuck = 0;

      // Reset in the second PULSE cycle
      a_req = 1; a_op = 0;
      tick(); cyc("t4c1", 0, 1, 1, 0, 0);
      tick(); cyc("t4c2", 0, 1, 1, 0, 0);
      rst = 1; a_req = 0;
      #1;
      cyc("t4rst", 1, 1, 0, 0, 0);
      tick(); rst = 0;
      tick(); cyc("t4idle0", 1, 1, 0, 0, 0);
      tick(); cyc("t4idle1", 1, 1, 0, 0, 0);
      a_req = 1; a_op = 1;
      tick(); cyc("t4n1", 1, 0, 1, 0, 0);
      repeat (4) tick();
      cyc("t4n5", 1, 1, 1, 1, 0);
      chk("t4n5.a_err", a_err, 0);
      a_req = 0;
      tick(); chk("t4.lp", lp, 1);

      // PW=0, ST=0 behaves as 1/1
      z_a_req = 1; z_a_op = 1;
      chk("t5c0.busy", z_busy, 0);
      tick();
      chk("t5c1.lh", z_lh, 0);
      chk("t5c1.busy", z_busy, 1);
      tick();
      chk("t5c2.lh", z_lh, 1);
      chk("t5c2.ack", z_a_ack, 0);
      tick();
      chk("t5c3.ack", z_a_ack, 1);
      chk("t5c3.err", z_a_err, 0);
      z_a_req = 0;
      tick();
      chk("t5c4.busy", z_busy, 0);
      chk("t5c4.lp", z_lp, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
